glitcbus_arbiter: RTL

//  Two-port WISHBONE-classic arbiter in front of the single GLITCBUS master port.

---
 rtl/glitcbus_arbiter_if.sv | 60 ++++++
 rtl/glitcbus_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/glitcbus_arbiter_if.sv
// Bundles the two requester WISHBONE ports, the GLITCBUS master port and status for the arbiter.
// Latency: none; this is wiring only, with names kept relative to the arbiter.
// Backpressure: carried by the ack/err signals; slave = arbiter side, master = environment side.
interface glitcbus_arbiter_if #(
  parameter int ADR_W = 18,
  parameter int CNT_W = 8
);
  // Requester 0 (PCI bridge master window)
  logic             m0_cyc_i;
  logic             m0_stb_i;
  logic             m0_we_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [31:0]      m0_dat_i;
  logic [31:0]      m0_dat_o;
  logic             m0_ack_o;
  logic             m0_err_o;
  // Requester 1 (internal sequencer)
  logic             m1_cyc_i;
  logic             m1_stb_i;
  logic             m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [31:0]      m1_dat_i;
  logic [31:0]      m1_dat_o;
  logic             m1_ack_o;
  logic             m1_err_o;
  // GLITCBUS master port
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [31:0]      s_dat_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  // Status / control
  logic             gready_i;
  logic [1:0]       grant_o;
  logic [CNT_W-1:0] timeout_count_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i,
    input  gready_i,
    output grant_o, timeout_count_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i,
    output gready_i,
    input  grant_o, timeout_count_o
  );
endinterface

// File: rtl/glitcbus_arbiter.sv
// Two-port round-robin WISHBONE-classic arbiter with cycle lock and ack timeout in front of GLITCBUS.
// Latency: grant registered (1 cycle IDLE->BUSY); ack/err/read data pass through combinationally.
// Backpressure: loser waits with outputs 0; stb is gated by gready_i, timeout returns err.
module glitcbus_arbiter #(
  parameter int ADR_W   = 18,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  glitcbus_arbiter_if.slave    bus
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             rr_q, rr_d;        // index of the port served last
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             req0, req1;
  logic             g_sel;
  logic             g_cyc, g_stb, g_we;
  logic [ADR_W-1:0] g_adr;
  logic [31:0]      g_dat;
  logic             busy, active, timeout_hit, ack, err;

  // Select the granted port's signals and derive the per-strobe handshake events.
  always_comb begin
    req0  = bus.m0_cyc_i & bus.m0_stb_i;
    req1  = bus.m1_cyc_i & bus.m1_stb_i;
    g_sel = grant_q[1];
    g_cyc = g_sel ? bus.m1_cyc_i : bus.m0_cyc_i;
    g_stb = g_sel ? bus.m1_stb_i : bus.m0_stb_i;
    g_we  = g_sel ? bus.m1_we_i  : bus.m0_we_i;
    g_adr = g_sel ? bus.m1_adr_i : bus.m0_adr_i;
    g_dat = g_sel ? bus.m1_dat_i : bus.m0_dat_i;
    busy  = (state_q == BUSY);
    // Reset low suppresses any handshake in the cycle before the reset edge lands.
    active      = busy & g_cyc & g_stb & rst_n_i;
    timeout_hit = active & bus.gready_i & (timer_q == TMR_LAST) & ~bus.s_ack_i;
    ack         = active & bus.gready_i & bus.s_ack_i;
    err         = active & (~bus.gready_i | timeout_hit);
  end

  // Next-state: arbitration in IDLE, cycle lock and ack timer in BUSY, timeout counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req0 | req1) begin
          state_d = BUSY;
          if (req0 & req1) begin
            grant_d = rr_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = req0 ? 2'b01 : 2'b10;
          end
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          // Release (normal end or abort): remember who just used the bus.
          state_d = IDLE;
          grant_d = 2'b00;
          rr_d    = g_sel;
          timer_d = '0;
        end else if (!active || bus.s_ack_i || err) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase
    if (timeout_hit && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // State register with synchronous active-low reset; rr starts as if m1 was served last.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b1;
      timer_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

  // GLITCBUS side: only the granted port's signals are ever forwarded.
  assign bus.s_cyc_o = busy;
  assign bus.s_stb_o = active & bus.gready_i & ~timeout_hit;
  assign bus.s_we_o  = busy & g_we;
  assign bus.s_adr_o = busy ? g_adr : '0;
  assign bus.s_dat_o = busy ? g_dat : '0;

  // Requester side: responses steered to the granted port, zero elsewhere.
  assign bus.m0_ack_o = ack & ~g_sel;
  assign bus.m1_ack_o = ack & g_sel;
  assign bus.m0_err_o = err & ~g_sel;
  assign bus.m1_err_o = err & g_sel;
  assign bus.m0_dat_o = (busy & ~g_sel) ? bus.s_dat_i : 32'h0;
  assign bus.m1_dat_o = (busy & g_sel)  ? bus.s_dat_i : 32'h0;

  assign bus.grant_o         = grant_q;
  assign bus.timeout_count_o = count_q;

endmodule
